// File: rtl/famicom_bus_bridge.sv
// Bridges the MCU FSMC bus (NE1 = cartridge CPU space, NE2 = PPU space) onto the
// Famicom cartridge bus, generating M2 locally and issuing one ROMSEL pulse per access.
module famicom_bus_bridge #(
    parameter int M2_HALF         = 8,
    parameter int LATE_LIMIT      = 3,
    parameter int READ_WAIT       = 5,
    parameter int WRITE_WAIT      = 7,
    parameter int LEDS_TIMER_SIZE = 12
) (
    input  logic       master_clock,
    input  logic       nreset,
    input  logic       ne1,
    input  logic       ne2,
    input  logic       nwe,
    input  logic       noe,
    input  logic       a13,
    input  logic       a15,
    output logic       nwait,
    output logic       m2,
    output logic       romsel,
    output logic       cpu_rw,
    output logic       cpu_oe,
    output logic       cpu_dir,
    output logic       flash_oe,
    output logic       flash_we,
    output logic       ppu_rd,
    output logic       ppu_wr,
    output logic       ppu_oe,
    output logic       ppu_dir,
    output logic       na13,
    output logic [3:0] leds
);

    localparam int PW = $clog2(2 * M2_HALF);
    localparam int WW = $clog2(M2_HALF);
    localparam int TW = LEDS_TIMER_SIZE + 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * M2_HALF - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(M2_HALF);
    localparam logic [PW-1:0] PHASE_LATE = PW'(LATE_LIMIT);
    localparam logic [WW-1:0] RD_LAST    = WW'(READ_WAIT - 1);
    localparam logic [WW-1:0] WR_LAST    = WW'(WRITE_WAIT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SETUP,
        STROBE,
        DONE,
        TAIL
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic            m2_q, m2_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            cpu_rw_q, cpu_rw_d;
    logic            cpu_oe_q, cpu_oe_d;
    logic            ne2_q;
    logic [1:0]      led_sel_q, led_sel_d;
    logic [TW-1:0]   led_timer_q, led_timer_d;

    logic ne1Active;
    logic isWr;
    logic busCycle;
    logic cpuEvent;
    logic ppuEvent;

    assign ne1Active = !ne1 && (!noe || !nwe);
    assign isWr      = !nwe;

    always_comb begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        m2_d    = (phase_d >= PHASE_HIGH);
    end

    // A held chip select parks in TAIL, so only a fresh access can reach STROBE again.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cpu_rw_d   = cpu_rw_q;
        cpu_oe_d   = cpu_oe_q;
        if (!ne1Active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = (!m2_q && (phase_q < PHASE_LATE)) ? SETUP : ALIGN;
                ALIGN:  if (phase_d == '0) state_d = SETUP;
                SETUP:  if (phase_d == PHASE_HIGH) state_d = STROBE;
                STROBE: begin
                    if (wait_cnt_q == (cpu_rw_q ? RD_LAST : WR_LAST)) begin
                        state_d = DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                DONE:   if (phase_d == '0) state_d = TAIL;
                TAIL:   state_d = TAIL;
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) begin
            wait_cnt_d = '0;
            cpu_rw_d   = 1'b1;
            cpu_oe_d   = 1'b1;
        end else begin
            if (state_d == SETUP) cpu_oe_d = 1'b0;
            if ((state_d == SETUP || state_q == SETUP) && isWr) cpu_rw_d = 1'b0;
        end
    end

    // A PPU event overrides a CPU event landing on the same clock.
    always_comb begin
        cpuEvent    = (state_q == IDLE) && ne1Active;
        ppuEvent    = ne2_q && !ne2 && (!noe || !nwe);
        led_sel_d   = led_sel_q;
        led_timer_d = led_timer_q;
        if (ppuEvent) begin
            led_sel_d   = !noe ? 2'd2 : 2'd3;
            led_timer_d = '0;
        end else if (cpuEvent) begin
            led_sel_d   = isWr ? 2'd1 : 2'd0;
            led_timer_d = '0;
        end else if (led_timer_q != TIMER_MAX) begin
            led_timer_d = led_timer_q + TW'(1);
        end
    end

    always_ff @(posedge master_clock or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            m2_q        <= 1'b0;
            wait_cnt_q  <= '0;
            cpu_rw_q    <= 1'b1;
            cpu_oe_q    <= 1'b1;
            ne2_q       <= 1'b1;
            led_sel_q   <= 2'd0;
            led_timer_q <= TIMER_MAX;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            m2_q        <= m2_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rw_q    <= cpu_rw_d;
            cpu_oe_q    <= cpu_oe_d;
            ne2_q       <= ne2;
            led_sel_q   <= led_sel_d;
            led_timer_q <= led_timer_d;
        end
    end

    assign busCycle = m2_q && a15 && ne1Active && (state_q == STROBE || state_q == DONE);

    assign m2       = m2_q;
    assign cpu_rw   = cpu_rw_q;
    assign cpu_oe   = cpu_oe_q;
    assign cpu_dir  = !cpu_rw_q;
    assign romsel   = !busCycle;
    assign flash_oe = !(busCycle && cpu_rw_q);
    assign flash_we = !(busCycle && !cpu_rw_q);
    assign nwait    = !(ne1Active && state_q != DONE && state_q != TAIL);

    assign ppu_rd  = !(!ne2 && !noe);
    assign ppu_wr  = !(!ne2 && !nwe);
    assign ppu_oe  = !(!ne2 && ne1);
    assign ppu_dir = ppu_rd;
    assign na13    = !a13;

    assign leds = (led_timer_q != TIMER_MAX) ? 4'(4'b0001 << led_sel_q) : 4'b0000;

endmodule

// File: tb/tb_famicom_bus_bridge.sv
// Scoreboard bench for famicom_bus_bridge at default parameters: expected CPU-bus
// traces are queued when an access is launched and popped as each clock is sampled.
module tb_famicom_bus_bridge;

    logic       master_clock = 1'b0;
    logic       nreset;
    logic       ne1, ne2, nwe, noe, a13, a15;
    logic       nwait, m2, romsel, cpu_rw, cpu_oe, cpu_dir, flash_oe, flash_we;
    logic       ppu_rd, ppu_wr, ppu_oe, ppu_dir, na13;
    logic [3:0] leds;

    int assertCount = 0;
    int failCount   = 0;
    int tbPhase;

    logic [15:0] expQ[$];
    string       tagQ[$];
    logic [7:0]  obs;

    famicom_bus_bridge dut (
        .master_clock(master_clock),
        .nreset      (nreset),
        .ne1         (ne1),
        .ne2         (ne2),
        .nwe         (nwe),
        .noe         (noe),
        .a13         (a13),
        .a15         (a15),
        .nwait       (nwait),
        .m2          (m2),
        .romsel      (romsel),
        .cpu_rw      (cpu_rw),
        .cpu_oe      (cpu_oe),
        .cpu_dir     (cpu_dir),
        .flash_oe    (flash_oe),
        .flash_we    (flash_we),
        .ppu_rd      (ppu_rd),
        .ppu_wr      (ppu_wr),
        .ppu_oe      (ppu_oe),
        .ppu_dir     (ppu_dir),
        .na13        (na13),
        .leds        (leds)
    );

    always #5 master_clock = ~master_clock;

    // Bench-side view of the M2 phase, used only to line accesses up with a phase.
    always @(posedge master_clock or negedge nreset) begin
        if (!nreset) tbPhase <= 0;
        else         tbPhase <= (tbPhase + 1) % 16;
    end

    assign obs = {nwait, m2, romsel, cpu_rw, cpu_oe, cpu_dir, flash_oe, flash_we};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Closed-form expectation for a CPU access detected at phase d, sampled t clocks later,
    // with ne1 released at t == h. Returns {care mask, value} over the obs vector.
    function automatic logic [15:0] cpuModel(input int d, input int t, input bit wr, input bit a15v, input int h);
        int         s, e, w, ph;
        bit         held, romLow;
        logic [7:0] v, m;
        s      = (d < 3) ? 8 - d : 24 - d;
        e      = (d < 3) ? 1 : 16 - d;
        w      = wr ? 7 : 5;
        held   = (t < h);
        ph     = (d + t) % 16;
        romLow = held && a15v && (t >= s) && (t <= s + 7);
        v[7]   = !(held && (t < s + w));
        v[6]   = (ph >= 8);
        v[5]   = !romLow;
        v[4]   = ((t >= s) && (t <= h)) ? !wr : 1'b1;
        v[3]   = !((t >= e) && (t <= h));
        v[2]   = !v[4];
        v[1]   = !(romLow && !wr);
        v[0]   = !(romLow && wr);
        m      = 8'hFF;
        if ((t >= e) && (t < s)) begin
            m[4] = 1'b0;
            m[2] = 1'b0;
        end
        return {m, v};
    endfunction

    task automatic waitPhase(input int d);
        for (int n = 0; n < 40; n++) begin
            @(negedge master_clock);
            if (tbPhase == d) break;
        end
        if (tbPhase != d) checkOutput("phaseAlign", tbPhase, d);
    endtask

    task automatic applyStimulus(input string name, input int d, input bit wr, input bit a15v,
                                 input int h, input logic [3:0] expLeds);
        logic [15:0] e;
        string       tg;
        for (int t = 0; t <= h + 2; t++) begin
            expQ.push_back(cpuModel(d, t, wr, a15v, h));
            tagQ.push_back($sformatf("%s_t%0d", name, t));
        end
        waitPhase(d);
        for (int t = 0; t <= h + 2; t++) begin
            if (t > 0) @(negedge master_clock);
            if (t == 0) begin
                ne1 = 1'b0;
                a15 = a15v;
                if (wr) nwe = 1'b0;
                else    noe = 1'b0;
            end
            if (t == h) begin
                ne1 = 1'b1;
                nwe = 1'b1;
                noe = 1'b1;
            end
            #1;
            e  = expQ.pop_front();
            tg = tagQ.pop_front();
            checkOutput(tg, obs & e[15:8], e[7:0] & e[15:8]);
            if (t == 3) checkOutput({name, "_leds"}, leds, expLeds);
        end
        a15 = 1'b0;
    endtask

    task automatic resetInStrobe();
        waitPhase(1);
        ne1 = 1'b0;
        nwe = 1'b0;
        a15 = 1'b1;
        repeat (9) @(negedge master_clock);
        #1;
        checkOutput("rstPreRomsel", romsel, 1'b0);
        nreset = 1'b0;
        #1;
        checkOutput("rstM2", m2, 1'b0);
        checkOutput("rstRomsel", romsel, 1'b1);
        checkOutput("rstCpuRw", cpu_rw, 1'b1);
        checkOutput("rstCpuOe", cpu_oe, 1'b1);
        checkOutput("rstFlashWe", flash_we, 1'b1);
        @(negedge master_clock);
        ne1 = 1'b1;
        nwe = 1'b1;
        a15 = 1'b0;
        @(negedge master_clock);
        nreset = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge master_clock);
            #1;
            checkOutput($sformatf("rstPhase_k%0d", k), m2, ((k % 16) >= 8));
        end
    endtask

    task automatic ppuReadLeds();
        int lit, other;
        lit   = 0;
        other = 0;
        @(negedge master_clock);
        ne2 = 1'b0;
        noe = 1'b0;
        #1;
        checkOutput("ppuRd", ppu_rd, 1'b0);
        checkOutput("ppuDirRd", ppu_dir, 1'b0);
        checkOutput("ppuOeRd", ppu_oe, 1'b0);
        checkOutput("ppuWrIdle", ppu_wr, 1'b1);
        for (int u = 1; u <= 8200; u++) begin
            @(negedge master_clock);
            if (u == 3) begin
                ne2 = 1'b1;
                noe = 1'b1;
            end
            #1;
            if (leds == 4'b0100)      lit++;
            else if (leds != 4'b0000) other++;
        end
        checkOutput("ppuLedOnTime", lit, 8191);
        checkOutput("ppuLedStray", other, 0);
        checkOutput("ppuLedOff", leds, 4'b0000);
    endtask

    task automatic ppuWriteAndA13();
        @(negedge master_clock);
        ne2 = 1'b0;
        nwe = 1'b0;
        a13 = 1'b1;
        #1;
        checkOutput("ppuWr", ppu_wr, 1'b0);
        checkOutput("ppuRdIdle", ppu_rd, 1'b1);
        checkOutput("ppuDirWr", ppu_dir, 1'b1);
        checkOutput("ppuOeWr", ppu_oe, 1'b0);
        checkOutput("na13High", na13, 1'b0);
        repeat (2) @(negedge master_clock);
        ne2 = 1'b1;
        nwe = 1'b1;
        a13 = 1'b0;
        #1;
        checkOutput("ppuWrLeds", leds, 4'b1000);
        checkOutput("na13Low", na13, 1'b1);
        checkOutput("ppuOeIdle", ppu_oe, 1'b1);
    endtask

    initial begin
        nreset = 1'b0;
        ne1 = 1'b1; ne2 = 1'b1; nwe = 1'b1; noe = 1'b1; a13 = 1'b0; a15 = 1'b0;
        repeat (3) @(negedge master_clock);
        #1;
        checkOutput("resetObs", obs, 8'hBB);
        checkOutput("resetLeds", leds, 4'b0000);
        @(negedge master_clock);
        nreset = 1'b1;

        applyStimulus("earlyRead", 1, 1'b0, 1'b1, 20, 4'b0001);
        applyStimulus("lateRead", 5, 1'b0, 1'b1, 30, 4'b0001);
        applyStimulus("writeLow", 1, 1'b1, 1'b0, 20, 4'b0010);
        applyStimulus("writeHigh", 2, 1'b1, 1'b1, 20, 4'b0010);
        applyStimulus("heldRead", 0, 1'b0, 1'b1, 50, 4'b0001);
        resetInStrobe();
        ppuReadLeds();
        applyStimulus("readAfterPpu", 1, 1'b0, 1'b1, 20, 4'b0001);
        ppuWriteAndA13();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
